// File: rtl/elevator_ctrl.sv
// Single-car SCAN elevator controller: latches car and hall calls, drives the
// motor and door, and shows the current floor.
module elevator_ctrl #(
  parameter int BUTTONS_WIDTH = 8,
  parameter int FLOOR_TICKS   = 2,
  parameter int DOOR_TICKS    = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             open_btn,
  input  logic                             close_btn,
  input  logic [BUTTONS_WIDTH-1:0]         btn_in,
  input  logic [BUTTONS_WIDTH-1:0]         btn_up_out,
  input  logic [BUTTONS_WIDTH-1:0]         btn_down_out,
  output logic [1:0]                       engine,
  output logic [1:0]                       door,
  output logic [$clog2(BUTTONS_WIDTH)-1:0] level_display
);

  localparam int FW = $clog2(BUTTONS_WIDTH);
  localparam int MW = $clog2(FLOOR_TICKS + 1);
  localparam int DW = $clog2(DOOR_TICKS + 1);
  localparam logic [FW-1:0] TOP_FLOOR = FW'(BUTTONS_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    MOVE_UP,
    MOVE_DOWN,
    DOOR_OPEN,
    DOOR_CLOSE
  } state_t;

  typedef enum logic {
    DIR_UP,
    DIR_DOWN
  } dir_t;

  state_t                   state, state_next;
  dir_t                     dir, dir_next;
  logic [FW-1:0]            floor, floor_next;
  logic [MW-1:0]            move_cnt, move_cnt_next;
  logic [DW-1:0]            door_cnt, door_cnt_next;
  logic [BUTTONS_WIDTH-1:0] req_in, req_up, req_down;
  logic [BUTTONS_WIDTH-1:0] pending, clear_mask;
  logic [1:0]               engine_next, door_next;
  logic [FW-1:0]            floor_up, floor_dn;
  logic                     above, below, go_up, go_down;

  function automatic logic any_above(input logic [BUTTONS_WIDTH-1:0] v,
                                     input logic [FW-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < BUTTONS_WIDTH; i++) begin
      if (i > int'(f)) r = r | v[i];
    end
    return r;
  endfunction

  function automatic logic any_below(input logic [BUTTONS_WIDTH-1:0] v,
                                     input logic [FW-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < BUTTONS_WIDTH; i++) begin
      if (i < int'(f)) r = r | v[i];
    end
    return r;
  endfunction

  assign pending       = req_in | req_up | req_down;
  assign level_display = floor;

  // Next-state logic; SCAN keeps the current direction while anything lies ahead.
  always_comb begin
    state_next    = state;
    dir_next      = dir;
    floor_next    = floor;
    move_cnt_next = move_cnt;
    door_cnt_next = door_cnt;
    floor_up      = floor + FW'(1);
    floor_dn      = floor - FW'(1);
    above         = any_above(pending, floor);
    below         = any_below(pending, floor);
    go_up         = (dir == DIR_UP)   ? above : (above && !below);
    go_down       = (dir == DIR_DOWN) ? below : (below && !above);

    case (state)
      IDLE: begin
        move_cnt_next = '0;
        door_cnt_next = '0;
        if (pending[floor] || open_btn) begin
          state_next = DOOR_OPEN;
        end else if (go_up) begin
          state_next = MOVE_UP;
          dir_next   = DIR_UP;
        end else if (go_down) begin
          state_next = MOVE_DOWN;
          dir_next   = DIR_DOWN;
        end
      end

      MOVE_UP: begin
        if (move_cnt == MW'(FLOOR_TICKS - 1)) begin
          move_cnt_next = '0;
          if (floor == TOP_FLOOR) begin
            state_next = IDLE;
          end else begin
            floor_next = floor_up;
            if (pending[floor_up]) begin
              state_next    = DOOR_OPEN;
              door_cnt_next = '0;
            end else if (!any_above(pending, floor_up)) begin
              state_next = IDLE;
            end
          end
        end else begin
          move_cnt_next = move_cnt + MW'(1);
        end
      end

      MOVE_DOWN: begin
        if (move_cnt == MW'(FLOOR_TICKS - 1)) begin
          move_cnt_next = '0;
          if (floor == '0) begin
            state_next = IDLE;
          end else begin
            floor_next = floor_dn;
            if (pending[floor_dn]) begin
              state_next    = DOOR_OPEN;
              door_cnt_next = '0;
            end else if (!any_below(pending, floor_dn)) begin
              state_next = IDLE;
            end
          end
        end else begin
          move_cnt_next = move_cnt + MW'(1);
        end
      end

      // open_btn takes priority over close_btn and over the timeout
      DOOR_OPEN: begin
        if (open_btn) begin
          door_cnt_next = '0;
        end else if (close_btn) begin
          state_next = DOOR_CLOSE;
        end else if (door_cnt == DW'(DOOR_TICKS - 1)) begin
          state_next = DOOR_CLOSE;
        end else begin
          door_cnt_next = door_cnt + DW'(1);
        end
      end

      DOOR_CLOSE: begin
        door_cnt_next = '0;
        state_next    = open_btn ? DOOR_OPEN : IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    engine_next = 2'b00;
    door_next   = 2'b00;
    clear_mask  = '0;
    case (state_next)
      MOVE_UP:    engine_next = 2'b01;
      MOVE_DOWN:  engine_next = 2'b10;
      DOOR_OPEN:  door_next   = 2'b01;
      DOOR_CLOSE: door_next   = 2'b10;
      default: ;
    endcase
    if (state_next == DOOR_OPEN) clear_mask[floor_next] = 1'b1;
  end

  // Calls at an open-door floor are swallowed instead of latched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      dir      <= DIR_UP;
      floor    <= '0;
      move_cnt <= '0;
      door_cnt <= '0;
      req_in   <= '0;
      req_up   <= '0;
      req_down <= '0;
      engine   <= 2'b00;
      door     <= 2'b00;
    end else begin
      state    <= state_next;
      dir      <= dir_next;
      floor    <= floor_next;
      move_cnt <= move_cnt_next;
      door_cnt <= door_cnt_next;
      req_in   <= (req_in   | btn_in)       & ~clear_mask;
      req_up   <= (req_up   | btn_up_out)   & ~clear_mask;
      req_down <= (req_down | btn_down_out) & ~clear_mask;
      engine   <= engine_next;
      door     <= door_next;
    end
  end

endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed bench for elevator_ctrl: travel, door timing, SCAN ordering and reset.
module tb_elevator_ctrl;

  logic       clk;
  logic       reset;
  logic       open_btn;
  logic       close_btn;
  logic [7:0] btn_in;
  logic [7:0] btn_up_out;
  logic [7:0] btn_down_out;
  logic [1:0] engine;
  logic [1:0] door;
  logic [2:0] level_display;

  int total_checks = 0;
  int bad_checks   = 0;

  elevator_ctrl #(
    .BUTTONS_WIDTH(8),
    .FLOOR_TICKS  (2),
    .DOOR_TICKS   (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .open_btn     (open_btn),
    .close_btn    (close_btn),
    .btn_in       (btn_in),
    .btn_up_out   (btn_up_out),
    .btn_down_out (btn_down_out),
    .engine       (engine),
    .door         (door),
    .level_display(level_display)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    total_checks++;
    if (actual != expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Holds the given buttons for one clock edge; returns on the following negedge.
  task automatic applyStimulus(input logic [7:0] in_v, input logic [7:0] up_v,
                               input logic [7:0] dn_v, input logic open_v,
                               input logic close_v);
    btn_in       = in_v;
    btn_up_out   = up_v;
    btn_down_out = dn_v;
    open_btn     = open_v;
    close_btn    = close_v;
    @(negedge clk);
    btn_in       = '0;
    btn_up_out   = '0;
    btn_down_out = '0;
    open_btn     = 1'b0;
    close_btn    = 1'b0;
  endtask

  // Current sample is door-open; expects 4 open cycles, one closing, then closed.
  task automatic door_check(input string tag);
    checkOutput({tag, "_open0"}, door, 1);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      checkOutput({tag, "_open"}, door, 1);
      checkOutput({tag, "_open_engine"}, engine, 0);
    end
    @(negedge clk);
    checkOutput({tag, "_closing"}, door, 2);
    @(negedge clk);
    checkOutput({tag, "_closed"}, door, 0);
  endtask

  // Current sample is idle with a request latched; expects travel from 'from'
  // to 'to' at 2 cycles per floor, optionally injecting a down call mid-trip.
  task automatic travel(input string tag, input int from, input int to,
                        input int inj_floor, input logic [7:0] inj_vec);
    int f;
    int code;
    checkOutput({tag, "_idle_engine"}, engine, 0);
    code = (to > from) ? 1 : 2;
    f = from;
    while (f != to) begin
      for (int c = 0; c < 2; c++) begin
        @(negedge clk);
        btn_down_out = '0;
        checkOutput({tag, "_level"}, level_display, f);
        checkOutput({tag, "_engine"}, engine, code);
        if (f == inj_floor && c == 0) btn_down_out = inj_vec;
      end
      f = (to > from) ? f + 1 : f - 1;
    end
    @(negedge clk);
    checkOutput({tag, "_arrive_level"}, level_display, to);
    checkOutput({tag, "_arrive_engine"}, engine, 0);
    checkOutput({tag, "_arrive_door"}, door, 1);
  endtask

  task automatic idle_hold(input string tag, input int lvl);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput({tag, "_engine"}, engine, 0);
      checkOutput({tag, "_door"}, door, 0);
      checkOutput({tag, "_level"}, level_display, lvl);
    end
  endtask

  initial begin
    int found;
    reset        = 1'b1;
    open_btn     = 1'b0;
    close_btn    = 1'b0;
    btn_in       = '0;
    btn_up_out   = '0;
    btn_down_out = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_engine", engine, 0);
    checkOutput("rst_door", door, 0);
    checkOutput("rst_level", level_display, 0);
    reset = 1'b0;

    $display("[TB] car call to top floor");
    applyStimulus(8'h80, 8'h00, 8'h00, 1'b0, 1'b0);
    travel("t1", 0, 7, -1, 8'h00);
    door_check("t1_door");

    $display("[TB] hall call at current floor");
    applyStimulus(8'h00, 8'h00, 8'h80, 1'b0, 1'b0);
    checkOutput("t2_latch_door", door, 0);
    @(negedge clk);
    checkOutput("t2_level", level_display, 7);
    checkOutput("t2_engine", engine, 0);
    door_check("t2_door");

    $display("[TB] reversal down to ground");
    applyStimulus(8'h00, 8'h01, 8'h00, 1'b0, 1'b0);
    travel("t3", 7, 0, -1, 8'h00);
    door_check("t3_door");
    idle_hold("t3_idle", 0);

    $display("[TB] scan order with mid-trip call");
    applyStimulus(8'h20, 8'h00, 8'h00, 1'b0, 1'b0);
    travel("t4a", 0, 3, 2, 8'h08);
    door_check("t4a_door");
    travel("t4b", 3, 5, -1, 8'h00);
    door_check("t4b_door");
    idle_hold("t4_idle", 5);

    $display("[TB] door buttons");
    applyStimulus(8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    checkOutput("t5_open", door, 1);
    repeat (2) begin
      @(negedge clk);
      checkOutput("t5_hold", door, 1);
    end
    applyStimulus(8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    door_check("t5_restart");
    applyStimulus(8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    checkOutput("t5_reopen", door, 1);
    applyStimulus(8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    checkOutput("t5_close_btn", door, 2);
    applyStimulus(8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    door_check("t5_open_in_close");
    checkOutput("t5_level", level_display, 5);

    $display("[TB] reset during motion");
    applyStimulus(8'h01, 8'h00, 8'h00, 1'b0, 1'b0);
    found = 0;
    for (int i = 0; i < 12 && found == 0; i++) begin
      @(negedge clk);
      if (level_display == 3'd4 && engine == 2'b10) found = 1;
    end
    checkOutput("t6_reach4", found, 1);
    reset = 1'b1;
    #1;
    checkOutput("t6_rst_engine", engine, 0);
    checkOutput("t6_rst_door", door, 0);
    checkOutput("t6_rst_level", level_display, 0);
    @(negedge clk);
    reset = 1'b0;
    idle_hold("t6_idle", 0);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
